axi_mem_slave: RTL

AXI4 memory-mapped subordinate that answers the manager ports (`M_AXI_*`) of `top`: it accepts write and read bursts, stores data in an internal word array, and returns B and R responses. It is the responder end of the cache's AXI manager interface. It replaces the open-loop stimulus currently used on that interface with a protocol-correct memory model, so the cache can be simulated end-to-end. It is also synthesizable as a small on-chip backing store.

---
 rtl/axi_mem_slave.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/axi_mem_slave.sv
// axi_mem_slave: AXI4 subordinate with independent write/read FSMs over an internal 64-bit word array; optional AXI_MEM_RANGE_CHECK_EN turns out-of-range beats into DECERR
module axi_mem_slave #(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 64,
  parameter int AXI_ID_WIDTH   = 4,
  parameter int MEM_DEPTH      = 1024
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [AXI_ID_WIDTH-1:0]     S_AXI_AWID,
  input  logic [7:0]                  S_AXI_AWLEN,
  input  logic [2:0]                  S_AXI_AWSIZE,
  input  logic [1:0]                  S_AXI_AWBURST,
  input  logic                        S_AXI_AWVALID,
  output logic                        S_AXI_AWREADY,
  input  logic [AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                        S_AXI_WLAST,
  input  logic                        S_AXI_WVALID,
  output logic                        S_AXI_WREADY,
  output logic [AXI_ID_WIDTH-1:0]     S_AXI_BID,
  output logic [1:0]                  S_AXI_BRESP,
  output logic                        S_AXI_BVALID,
  input  logic                        S_AXI_BREADY,
  input  logic [AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [AXI_ID_WIDTH-1:0]     S_AXI_ARID,
  input  logic [7:0]                  S_AXI_ARLEN,
  input  logic [2:0]                  S_AXI_ARSIZE,
  input  logic [1:0]                  S_AXI_ARBURST,
  input  logic                        S_AXI_ARVALID,
  output logic                        S_AXI_ARREADY,
  output logic [AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [AXI_ID_WIDTH-1:0]     S_AXI_RID,
  output logic [1:0]                  S_AXI_RRESP,
  output logic                        S_AXI_RLAST,
  output logic                        S_AXI_RVALID,
  input  logic                        S_AXI_RREADY
);
  localparam int IW = $clog2(MEM_DEPTH);
  localparam logic [1:0] OKAY = 2'b00, SLVERR = 2'b10, DECERR = 2'b11;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;
  function automatic logic [AXI_ADDR_WIDTH-1:0] f_next(input logic [AXI_ADDR_WIDTH-1:0] a, input logic [7:0] len, input logic [1:0] burst);
    logic [AXI_ADDR_WIDTH-1:0] m;
    m = AXI_ADDR_WIDTH'({len, 3'b111});
    return burst == 2'b00 ? a : burst == 2'b10 ? (a & ~m) | ((a + AXI_ADDR_WIDTH'(8)) & m) : a + AXI_ADDR_WIDTH'(8);
  endfunction
  function automatic logic f_err(input logic [2:0] size, input logic [1:0] burst, input logic [7:0] len);
    return size != 3'd3 || burst == 2'b11 ||
           (burst == 2'b10 && !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15));
  endfunction
  logic [AXI_DATA_WIDTH-1:0] r_mem [0:MEM_DEPTH-1];
  w_state_t                  r_wstate;
  logic [AXI_ADDR_WIDTH-1:0] r_awaddr;
  logic [7:0]                r_awlen, r_wcnt;
  logic [1:0]                r_awburst, r_bresp;
  logic                      r_werr, r_wslv, r_wdec, r_awready, r_wready, r_bvalid;
  logic [AXI_ID_WIDTH-1:0]   r_bid;
  r_state_t                  r_rstate;
  logic [AXI_ADDR_WIDTH-1:0] r_araddr;
  logic [7:0]                r_arlen, r_rcnt;
  logic [1:0]                r_arburst, r_rresp;
  logic                      r_rerr, r_arready, r_rvalid, r_rlast;
  logic [AXI_ID_WIDTH-1:0]   r_rid;
  logic [AXI_DATA_WIDTH-1:0] r_rdata;
  logic w_aw_hs, w_w_hs, w_b_hs, w_wlast_beat, w_wlast_bad, w_wr_en, w_woor;
  logic w_ar_hs, w_r_hs, w_rerr_new, w_roor, w_unused;
  logic [AXI_ADDR_WIDTH-1:0] w_rnext, w_rd_addr;
  logic [AXI_DATA_WIDTH-1:0] w_rd_word;
  assign w_aw_hs      = S_AXI_AWVALID & r_awready;
  assign w_w_hs       = S_AXI_WVALID & r_wready;
  assign w_b_hs       = S_AXI_BREADY & r_bvalid;
  assign w_wlast_beat = r_wcnt == r_awlen;
  assign w_wlast_bad  = S_AXI_WLAST != w_wlast_beat;
  assign w_wr_en      = w_w_hs & ~r_werr & ~w_woor;
  assign w_ar_hs      = S_AXI_ARVALID & r_arready;
  assign w_r_hs       = r_rvalid & S_AXI_RREADY;
  assign w_rerr_new   = f_err(S_AXI_ARSIZE, S_AXI_ARBURST, S_AXI_ARLEN);
  assign w_rnext      = f_next(r_araddr, r_arlen, r_arburst);
  assign w_rd_addr    = r_rstate == R_IDLE ? S_AXI_ARADDR : w_rnext;
  assign w_rd_word    = r_mem[w_rd_addr[3 +: IW]];
  assign w_unused     = ^w_rd_addr;
`ifdef AXI_MEM_RANGE_CHECK_EN
  assign w_woor = (r_awaddr >> 3) >= AXI_ADDR_WIDTH'(MEM_DEPTH);
  assign w_roor = (w_rd_addr >> 3) >= AXI_ADDR_WIDTH'(MEM_DEPTH);
`else
  assign w_woor = 1'b0;
  assign w_roor = 1'b0;
`endif
  assign S_AXI_AWREADY = r_awready;
  assign S_AXI_WREADY  = r_wready;
  assign S_AXI_BID     = r_bid;
  assign S_AXI_BRESP   = r_bresp;
  assign S_AXI_BVALID  = r_bvalid;
  assign S_AXI_ARREADY = r_arready;
  assign S_AXI_RDATA   = r_rdata;
  assign S_AXI_RID     = r_rid;
  assign S_AXI_RRESP   = r_rresp;
  assign S_AXI_RLAST   = r_rlast;
  assign S_AXI_RVALID  = r_rvalid;
  // write FSM: take AW, count W beats accumulating error flags, then hold B until accepted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wstate  <= W_IDLE;
      r_awready <= 1'b1;
      r_wready  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bid     <= '0;
      r_bresp   <= OKAY;
      r_awaddr  <= '0;
      r_awlen   <= '0;
      r_awburst <= '0;
      r_wcnt    <= '0;
      r_werr    <= 1'b0;
      r_wslv    <= 1'b0;
      r_wdec    <= 1'b0;
    end else begin
      case (r_wstate)
        W_IDLE: if (w_aw_hs) begin
          r_awaddr  <= S_AXI_AWADDR;
          r_bid     <= S_AXI_AWID;
          r_awlen   <= S_AXI_AWLEN;
          r_awburst <= S_AXI_AWBURST;
          r_werr    <= f_err(S_AXI_AWSIZE, S_AXI_AWBURST, S_AXI_AWLEN);
          r_wslv    <= 1'b0;
          r_wdec    <= 1'b0;
          r_wcnt    <= '0;
          r_awready <= 1'b0;
          r_wready  <= 1'b1;
          r_wstate  <= W_DATA;
        end
        W_DATA: if (w_w_hs) begin
          r_awaddr <= f_next(r_awaddr, r_awlen, r_awburst);
          r_wcnt   <= r_wcnt + 8'd1;
          r_wslv   <= r_wslv | w_wlast_bad;
          r_wdec   <= r_wdec | w_woor;
          if (w_wlast_beat) begin
            r_wready <= 1'b0;
            r_bvalid <= 1'b1;
            r_bresp  <= r_werr ? SLVERR : (r_wdec | w_woor) ? DECERR : (r_wslv | w_wlast_bad) ? SLVERR : OKAY;
            r_wstate <= W_RESP;
          end
        end
        W_RESP: if (w_b_hs) begin
          r_bvalid  <= 1'b0;
          r_awready <= 1'b1;
          r_wstate  <= W_IDLE;
        end
        default: r_wstate <= W_IDLE;
      endcase
    end
  end
  // byte-lane writes; the array is kept out of reset so committed data survives it
  always_ff @(posedge clk) begin
    if (w_wr_en)
      for (int b = 0; b < AXI_DATA_WIDTH / 8; b++)
        if (S_AXI_WSTRB[b]) r_mem[r_awaddr[3 +: IW]][8*b +: 8] <= S_AXI_WDATA[8*b +: 8];
  end
  // read FSM: preload the first beat on AR, then reload on each accepted non-last beat
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rstate  <= R_IDLE;
      r_arready <= 1'b1;
      r_rvalid  <= 1'b0;
      r_rlast   <= 1'b0;
      r_rdata   <= '0;
      r_rresp   <= OKAY;
      r_rid     <= '0;
      r_araddr  <= '0;
      r_arlen   <= '0;
      r_arburst <= '0;
      r_rcnt    <= '0;
      r_rerr    <= 1'b0;
    end else if (r_rstate == R_IDLE) begin
      if (w_ar_hs) begin
        r_araddr  <= S_AXI_ARADDR;
        r_arlen   <= S_AXI_ARLEN;
        r_arburst <= S_AXI_ARBURST;
        r_rid     <= S_AXI_ARID;
        r_rerr    <= w_rerr_new;
        r_rcnt    <= '0;
        r_rlast   <= S_AXI_ARLEN == 8'd0;
        r_rdata   <= (w_rerr_new | w_roor) ? '0 : w_rd_word;
        r_rresp   <= w_rerr_new ? SLVERR : w_roor ? DECERR : OKAY;
        r_rvalid  <= 1'b1;
        r_arready <= 1'b0;
        r_rstate  <= R_DATA;
      end
    end else if (w_r_hs) begin
      if (r_rlast) begin
        r_rvalid  <= 1'b0;
        r_rlast   <= 1'b0;
        r_arready <= 1'b1;
        r_rstate  <= R_IDLE;
      end else begin
        r_araddr <= w_rnext;
        r_rcnt   <= r_rcnt + 8'd1;
        r_rlast  <= r_rcnt + 8'd1 == r_arlen;
        r_rdata  <= (r_rerr | w_roor) ? '0 : w_rd_word;
        r_rresp  <= r_rerr ? SLVERR : w_roor ? DECERR : OKAY;
      end
    end
  end
endmodule
